rr_grant_arbiter: RTL and testbench

//  Parametrised round-robin arbiter for NUM_REQ requesters. Registered grant is one-hot,
//  or all-zero when idle. Grant is held while the owner keeps requesting, capped at MAX_HOLD cycles.

---
 rtl/rr_grant_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with a registered one-hot grant,
// owner hold capped at MAX_HOLD cycles (0 = unlimited).
// Optional feature macro RR_ARB_ONEHOT_CHK_EN: sticky registered one-hot
// self-check on the grant register plus concurrent assertions. When the macro
// is undefined, onehot_err is tied low and no assertions are compiled.
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       onehot_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     win_nxt;
  logic              owner_req;
  logic              others_req;
  logic              hold_expired;

  // Round-robin search starting at ptr_q; ptr_q always sits one past the
  // current owner, so the owner is the last candidate considered.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign win_nxt      = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  assign owner_req    = |(req & gnt_q);
  assign others_req   = |(req & ~gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD));

  // Next-state and next-grant logic; every path defaults to holding state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d   = win_idx;
          ptr_d   = win_nxt;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (!owner_req || (hold_expired && others_req)) begin
          // Release or forced handover: re-arbitrate in the same edge.
          if (win_found) begin
            gnt_d   = '0;
            gnt_d[win_idx] = 1'b1;
            idx_d   = win_idx;
            ptr_d   = win_nxt;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else if (!hold_expired && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, grant, pointer and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = idx_q;

`ifdef RR_ARB_ONEHOT_CHK_EN
  logic err_q;

  // Sticky flag: set one cycle after the grant register holds more than one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if ((gnt_q & (gnt_q - 1'b1)) != '0) err_q <= 1'b1;
  end

  assign onehot_err = err_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("rr_grant_arbiter: grant not one-hot: %b", gnt);

  a_gnt_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt)
    else $error("rr_grant_arbiter: gnt_valid inconsistent with gnt");
`else
  assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NUM_REQ=5, MAX_HOLD=4).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       onehot_err;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_arbiter #(.NUM_REQ(5), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .onehot_err(onehot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold reset for two edges, release away from the edge with req idle
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 5'b00000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 5'b11111;
    step();
    step();
    n_checks++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || onehot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b valid=%b idx=%0d err=%b, want 00000/0/0/0",
               gnt, gnt_valid, gnt_idx, onehot_err);
    end
    req   = 5'b00000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100;
    for (int k = 0; k < 7; k++) begin
      step();
      n_checks++;
      if (gnt !== 5'b00100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single[%0d]: gnt=%b idx=%0d valid=%b, want 00100/2/1",
                 k, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 5'b00000;
    step();
    n_checks++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL single_idle: gnt=%b valid=%b idx=%0d, want 00000/0/0", gnt, gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_fairness();
    logic [4:0] exp_g;
    logic [2:0] exp_i;
    do_reset();
    req = 5'b11111;
    for (int k = 0; k < 24; k++) begin
      step();
      exp_i = 3'((k / 4) % 5);
      exp_g = 5'b00001 << exp_i;
      n_checks++;
      if (gnt !== exp_g || gnt_idx !== exp_i) begin
        n_fail++;
        $display("FAIL fairness[%0d]: gnt=%b idx=%0d, want %b/%0d", k, gnt, gnt_idx, exp_g, exp_i);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 5'b00101;
    step();
    n_checks++;
    if (gnt !== 5'b00001) begin
      n_fail++;
      $display("FAIL release_first: gnt=%b, want 00001", gnt);
    end
    req = 5'b00100;
    step();
    n_checks++;
    if (gnt !== 5'b00100 || gnt_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL release_handover: gnt=%b idx=%0d, want 00100/2", gnt, gnt_idx);
    end
    req = 5'b00000;
    step();
    n_checks++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle: gnt=%b valid=%b, want 00000/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_midgrant_reset();
    do_reset();
    req = 5'b01000;
    step();
    n_checks++;
    if (gnt !== 5'b01000 || gnt_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL midrst_grant: gnt=%b idx=%0d, want 01000/3", gnt, gnt_idx);
    end
    req = 5'b11111;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 5'b00000 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_async: gnt=%b valid=%b idx=%0d, want 00000/0/0", gnt, gnt_valid, gnt_idx);
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (gnt !== 5'b00001 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: gnt=%b idx=%0d, want 00001/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_onehot_chk();
`ifdef RR_ARB_ONEHOT_CHK_EN
    do_reset();
    req = 5'b00001;
    step();
    force dut.gnt_q = 5'b00011;
    step();
    release dut.gnt_q;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (onehot_err !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot_err_sticky[%0d]: err=%b, want 1", k, onehot_err);
      end
      step();
    end
    do_reset();
`endif
    n_checks++;
    if (onehot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL onehot_err_clear: err=%b, want 0", onehot_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 5'b00000;
    test_reset();
    test_single();
    test_fairness();
    test_release();
    test_midgrant_reset();
    test_onehot_chk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
